multi_road_traffic_ctrl: RTL and testbench

- Parametrised highway/side-road traffic light controller: one highway, NUM_SIDE side roads, each with its own car sensor.
- Round-robin service of side-road requests; enforced minimum highway green and maximum side green.
- Time-of-day night flashing mode; emergency/pedestrian all-red pre-emption keyed by an ASCII code ('a','b','c').
- Sits between the time-of-day counter and the lamp drivers in the intersection top level.

---
 rtl/traffic_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/multi_road_traffic_ctrl.sv | 167 ++++++++++++++++
 tb/tb_multi_road_traffic_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the highway/side-road traffic controller.
//   - lamp encodings (RED/YELLOW/GREEN)
//   - controller state enum
//   - accepted emergency request codes and a helper to match them
//   - night flash half-period
package traffic_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  typedef enum logic [2:0] {
    HWY_G, HWY_Y, ALL_R, SIDE_G, SIDE_Y, ALL_R2, NIGHT, EMG
  } state_t;

  localparam logic [7:0] CHAR_A = 8'h61;
  localparam logic [7:0] CHAR_B = 8'h62;
  localparam logic [7:0] CHAR_C = 8'h63;

  localparam int FLASH_CYCLES = 4;

  function automatic logic is_emg_char(input logic [7:0] c);
    return (c == CHAR_A) || (c == CHAR_B) || (c == CHAR_C);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after ptr,
// wrapping at N. With N=1 the grant is always road 0.
//   req   : request vector
//   ptr   : last granted index
//   en    : arbitration enable (valid is gated by it)
//   grant : granted index
//   valid : a request was granted
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [IW-1:0] grant,
  output logic          valid
);

  generate
    if (N == 1) begin : g_single
      logic unused_ptr;
      assign unused_ptr = ^ptr;
      assign grant      = '0;
      assign valid      = en & req[0];
    end else begin : g_rr
      logic [IW:0]   sum;
      logic [IW-1:0] idx;
      logic          hit;
      // Scan from farthest to nearest so the nearest requester after ptr
      // is the last (winning) assignment.
      always_comb begin
        sum   = '0;
        idx   = '0;
        hit   = 1'b0;
        grant = '0;
        for (int i = N; i >= 1; i--) begin
          sum = {1'b0, ptr} + (IW+1)'(i);
          if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
          idx = sum[IW-1:0];
          if (req[idx]) begin
            grant = idx;
            hit   = 1'b1;
          end
        end
        valid = hit & en;
      end
    end
  endgenerate

endmodule

// File: rtl/multi_road_traffic_ctrl.sv
// Highway / multi side-road traffic light controller.
// Highway green by default; side roads served round-robin with a minimum
// highway green between services, night flashing mode by time of day and
// all-red emergency pre-emption keyed by an ASCII code.
// Ports:
//   clock, clear      : clock, async active-low reset
//   hours, minutes    : time of day
//   car_det           : per side road car sensor (level)
//   emg_valid/char    : emergency request strobe and code
//   hwy, side         : registered lamp outputs (RED=00 YELLOW=01 GREEN=10)
//   side_sel          : side road currently or last served
//   night, emg_ack    : night mode flag, request-accepted pulse
//   time_err          : combinational out-of-range time flag
module multi_road_traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_SIDE       = 2,
  parameter int MIN_GREEN      = 8,
  parameter int MAX_SIDE_GREEN = 6,
  parameter int Y_CYCLES       = 3,
  parameter int R_CYCLES       = 2,
  parameter int EMG_CYCLES     = 10,
  parameter int NIGHT_START_H  = 21,
  parameter int DAY_START_H    = 5,
  localparam int SW = (NUM_SIDE > 1) ? $clog2(NUM_SIDE) : 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [4:0]            hours,
  input  logic [5:0]            minutes,
  input  logic [NUM_SIDE-1:0]   car_det,
  input  logic                  emg_valid,
  input  logic [7:0]            emg_char,
  output logic [1:0]            hwy,
  output logic [2*NUM_SIDE-1:0] side,
  output logic [SW-1:0]         side_sel,
  output logic                  night,
  output logic                  emg_ack,
  output logic                  time_err
);

  localparam int TMAX = max2(max2(max2(MIN_GREEN, MAX_SIDE_GREEN),
                                  max2(Y_CYCLES, R_CYCLES)), EMG_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FW   = $clog2(2 * FLASH_CYCLES);

  state_t        state, next_state;
  logic [TW-1:0] timer;
  logic [FW-1:0] flash_cnt;
  logic [SW-1:0] rr_ptr, arb_gnt;
  logic          arb_en, arb_vld;
  logic          emg_pending, emg_take, is_night, entering;
  logic          g_done, sg_done, y_done, r_done, e_done;
  logic [1:0]    hwy_d, side_lamp;
  logic [2*NUM_SIDE-1:0] side_d;

  assign time_err = (hours > 5'd23) | (minutes > 6'd59);

  // Bad time input falls back to day operation.
  assign is_night = !time_err &&
                    ((hours > 5'(NIGHT_START_H)) ||
                     (hours == 5'(NIGHT_START_H) && minutes >= 6'd1) ||
                     (hours < 5'(DAY_START_H)));

  assign g_done  = timer >= TW'(MIN_GREEN - 1);
  assign sg_done = timer >= TW'(MAX_SIDE_GREEN - 1);
  assign y_done  = timer >= TW'(Y_CYCLES - 1);
  assign r_done  = timer >= TW'(R_CYCLES - 1);
  assign e_done  = timer >= TW'(EMG_CYCLES - 1);

  assign emg_take = emg_valid && is_emg_char(emg_char) && !emg_pending;
  assign entering = next_state != state;

  rr_arbiter #(.N(NUM_SIDE)) u_arb (
    .req   (car_det),
    .ptr   (rr_ptr),
    .en    (arb_en),
    .grant (arb_gnt),
    .valid (arb_vld)
  );

  always_comb begin
    next_state = state;
    arb_en     = 1'b0;
    case (state)
      HWY_G:  if (g_done && (|car_det || emg_pending || is_night)) next_state = HWY_Y;
      HWY_Y:  if (y_done) next_state = ALL_R;
      ALL_R: begin
        arb_en = r_done && !emg_pending && !is_night;
        if (r_done) begin
          if (emg_pending)  next_state = EMG;
          else if (is_night) next_state = NIGHT;
          else if (arb_vld)  next_state = SIDE_G;
          else               next_state = HWY_G;
        end
      end
      SIDE_G: if (!car_det[side_sel] || sg_done || emg_pending) next_state = SIDE_Y;
      SIDE_Y: if (y_done) next_state = ALL_R2;
      ALL_R2: if (r_done) next_state = emg_pending ? EMG : HWY_G;
      NIGHT: begin
        if (emg_pending)   next_state = EMG;
        else if (!is_night) next_state = ALL_R2;
      end
      EMG:    if (e_done) next_state = ALL_R2;
      default: next_state = HWY_G;
    endcase
  end

  // Lamp decode of the current state; registered below, so lamps trail
  // the state register by one cycle.
  always_comb begin
    hwy_d     = RED;
    side_lamp = RED;
    case (state)
      HWY_G:  hwy_d     = GREEN;
      HWY_Y:  hwy_d     = YELLOW;
      SIDE_G: side_lamp = GREEN;
      SIDE_Y: side_lamp = YELLOW;
      NIGHT:  hwy_d     = (flash_cnt < FW'(FLASH_CYCLES)) ? YELLOW : RED;
      default: ;
    endcase
  end

  generate
    for (genvar g = 0; g < NUM_SIDE; g++) begin : g_lane
      assign side_d[2*g +: 2] = (side_sel == SW'(g)) ? side_lamp : RED;
    end
  endgenerate

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= HWY_G;
      timer       <= '0;
      flash_cnt   <= '0;
      side_sel    <= '0;
      rr_ptr      <= SW'(NUM_SIDE - 1);
      emg_pending <= 1'b0;
      emg_ack     <= 1'b0;
      night       <= 1'b0;
      hwy         <= GREEN;
      side        <= '0;
    end else begin
      state <= next_state;
      if (entering)          timer <= '0;
      else if (timer != '1)  timer <= timer + TW'(1);

      if (entering) flash_cnt <= '0;
      else if (state == NIGHT)
        flash_cnt <= (flash_cnt == FW'(2*FLASH_CYCLES - 1)) ? '0 : flash_cnt + FW'(1);

      if (arb_vld) begin
        side_sel <= arb_gnt;
        rr_ptr   <= arb_gnt;
      end

      // Cleared on EMG entry so a request arriving during EMG is kept.
      if (next_state == EMG && state != EMG) emg_pending <= 1'b0;
      else if (emg_take)                     emg_pending <= 1'b1;
      emg_ack <= emg_take;

      night <= (state == NIGHT);
      hwy   <= hwy_d;
      side  <= side_d;
    end
  end

endmodule

// File: tb/tb_multi_road_traffic_ctrl.sv
module tb_multi_road_traffic_ctrl;

  localparam int NS = 2;
  localparam logic [1:0] G = 2'b10, Y = 2'b01, R = 2'b00;
  localparam logic [3:0] S0G = 4'b0010, S0Y = 4'b0001;
  localparam logic [3:0] S1G = 4'b1000, S1Y = 4'b0100;

  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic [4:0]    hours = 5'd10;
  logic [5:0]    minutes = 6'd0;
  logic [NS-1:0] car_det = '0;
  logic          emg_valid = 1'b0;
  logic [7:0]    emg_char = 8'h00;
  logic [1:0]    hwy;
  logic [2*NS-1:0] side;
  logic [0:0]    side_sel;
  logic          night, emg_ack, time_err;

  int nvec = 0;
  int nerr = 0;

  multi_road_traffic_ctrl #(.NUM_SIDE(NS)) dut (
    .clock     (clock),
    .clear     (clear),
    .hours     (hours),
    .minutes   (minutes),
    .car_det   (car_det),
    .emg_valid (emg_valid),
    .emg_char  (emg_char),
    .hwy       (hwy),
    .side      (side),
    .side_sel  (side_sel),
    .night     (night),
    .emg_ack   (emg_ack),
    .time_err  (time_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  // n cycles, checking lamps after each edge
  task automatic run(input int n, input logic [1:0] eh, input logic [3:0] es, input string tag);
    repeat (n) begin
      tick();
      chk({tag, ".hwy"}, 32'(hwy), 32'(eh));
      chk({tag, ".side"}, 32'(side), 32'(es));
    end
  endtask

  // Reset is released on a falling edge; the next rising edge is the first.
  task automatic do_reset;
    emg_valid = 1'b0;
    clear = 1'b0;
    @(negedge clock);
    @(negedge clock);
    clear = 1'b1;
  endtask

  initial begin
    #1;
    // Idle highway
    hours = 5'd10; car_det = 2'b00;
    do_reset();
    chk("rst.hwy", 32'(hwy), 32'(G));
    chk("rst.side", 32'(side), 32'(0));
    chk("rst.night", 32'(night), 32'(0));
    chk("rst.ack", 32'(emg_ack), 32'(0));
    chk("rst.sel", 32'(side_sel), 32'(0));
    chk("rst.terr", 32'(time_err), 32'(0));
    run(50, G, 4'b0000, "idle");
    chk("idle.night", 32'(night), 32'(0));

    // Single car on road 0, leaves early
    car_det = 2'b00;
    do_reset();
    run(2, G, 4'b0000, "t2.g0");
    car_det = 2'b01;
    run(6, G, 4'b0000, "t2.g1");
    run(3, Y, 4'b0000, "t2.hy");
    run(2, R, 4'b0000, "t2.ar");
    run(2, R, S0G, "t2.sg");
    car_det = 2'b00;
    run(1, R, S0G, "t2.sg2");
    run(3, R, S0Y, "t2.sy");
    run(2, R, 4'b0000, "t2.ar2");
    run(3, G, 4'b0000, "t2.hg");

    // Both roads busy: max green and alternation
    car_det = 2'b11;
    do_reset();
    run(8, G, 4'b0000, "t3.g");
    run(3, Y, 4'b0000, "t3.y");
    run(2, R, 4'b0000, "t3.r");
    run(6, R, S0G, "t3.s0g");
    chk("t3.sel0", 32'(side_sel), 32'(0));
    run(3, R, S0Y, "t3.s0y");
    run(2, R, 4'b0000, "t3.r2");
    run(8, G, 4'b0000, "t3.g2");
    run(3, Y, 4'b0000, "t3.y2");
    run(2, R, 4'b0000, "t3.r3");
    run(6, R, S1G, "t3.s1g");
    chk("t3.sel1", 32'(side_sel), 32'(1));
    run(3, R, S1Y, "t3.s1y");
    run(2, R, 4'b0000, "t3.r4");
    run(8, G, 4'b0000, "t3.g3");
    run(3, Y, 4'b0000, "t3.y3");
    run(2, R, 4'b0000, "t3.r5");
    run(6, R, S0G, "t3.s0g2");
    chk("t3.sel2", 32'(side_sel), 32'(0));

    // Night at 21:01, back to day at 05:00
    hours = 5'd21; minutes = 6'd1; car_det = 2'b00;
    do_reset();
    chk("t4.night0", 32'(night), 32'(0));
    run(8, G, 4'b0000, "t4.g");
    run(3, Y, 4'b0000, "t4.y");
    run(2, R, 4'b0000, "t4.r");
    chk("t4.night1", 32'(night), 32'(0));
    run(4, Y, 4'b0000, "t4.fy");
    chk("t4.night2", 32'(night), 32'(1));
    car_det = 2'b01;
    run(4, R, 4'b0000, "t4.fr");
    run(4, Y, 4'b0000, "t4.fy2");
    hours = 5'd5; minutes = 6'd0;
    run(1, R, 4'b0000, "t4.fr2");
    chk("t4.night3", 32'(night), 32'(1));
    run(2, R, 4'b0000, "t4.ar2");
    chk("t4.night4", 32'(night), 32'(0));
    run(1, G, 4'b0000, "t4.hg");

    // Emergency 'a' during side green, 'b' while pending, 'd' ignored
    hours = 5'd10; minutes = 6'd0; car_det = 2'b01;
    do_reset();
    run(8, G, 4'b0000, "t5.g");
    run(3, Y, 4'b0000, "t5.y");
    run(2, R, 4'b0000, "t5.r");
    run(1, R, S0G, "t5.sg");
    emg_valid = 1'b1; emg_char = 8'h61;
    run(1, R, S0G, "t5.sg2");
    chk("t5.ack_a", 32'(emg_ack), 32'(1));
    emg_char = 8'h62;
    run(1, R, S0G, "t5.sg3");
    chk("t5.ack_b", 32'(emg_ack), 32'(0));
    emg_valid = 1'b0;
    run(3, R, S0Y, "t5.sy");
    run(14, R, 4'b0000, "t5.emg");
    car_det = 2'b00;
    run(1, G, 4'b0000, "t5.hg");
    emg_valid = 1'b1; emg_char = 8'h64;
    run(1, G, 4'b0000, "t5.hg2");
    chk("t5.ack_d", 32'(emg_ack), 32'(0));
    emg_valid = 1'b0;
    run(10, G, 4'b0000, "t5.hold");

    // Bad time -> day behaviour; reset mid side yellow
    hours = 5'd25; minutes = 6'd0; car_det = 2'b01;
    do_reset();
    chk("t6.terr", 32'(time_err), 32'(1));
    run(8, G, 4'b0000, "t6.g");
    run(3, Y, 4'b0000, "t6.y");
    run(2, R, 4'b0000, "t6.r");
    chk("t6.night", 32'(night), 32'(0));
    run(2, R, S0G, "t6.sg");
    car_det = 2'b00;
    run(1, R, S0G, "t6.sg2");
    run(2, R, S0Y, "t6.sy");
    clear = 1'b0;
    #1;
    chk("t6.rst_hwy", 32'(hwy), 32'(G));
    chk("t6.rst_side", 32'(side), 32'(0));
    chk("t6.rst_sel", 32'(side_sel), 32'(0));
    hours = 5'd10; minutes = 6'd60;
    #1 chk("t6.terr_min", 32'(time_err), 32'(1));
    hours = 5'd23; minutes = 6'd59;
    #1 chk("t6.terr_ok", 32'(time_err), 32'(0));
    hours = 5'd24; minutes = 6'd0;
    #1 chk("t6.terr_hr", 32'(time_err), 32'(1));
    clear = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
